// File: rtl/regfile_mp_sb_pkg.sv
// Shared constants for the multi-port register file and its busy scoreboard.
package regfile_mp_sb_pkg;

  localparam int unsigned XLEN_DEF = 64;
  localparam int unsigned AW_DEF   = 5;

  localparam logic [XLEN_DEF-1:0] ZEROWORD = '0;

  localparam logic RD_EN      = 1'b1;
  localparam logic WR_EN      = 1'b1;
  // Reset is active-low for this block.
  localparam logic RST_ACTIVE = 1'b0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard. Priority: flush, then issue-set, then writeback clear.
module regfile_scoreboard
  import regfile_mp_sb_pkg::*;
#(
  parameter int unsigned NREG    = 32,
  parameter int unsigned AW      = $clog2(NREG),
  parameter int unsigned NWR     = 2,
  parameter bit          ZERO_R0 = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_set,
  input  logic [AW-1:0]     iss_addr,
  input  logic              flush,
  input  logic [NWR-1:0]    clr_en,
  input  logic [NWR*AW-1:0] clr_addr,
  output logic [NREG-1:0]   busy_vec,
  output logic [AW:0]       busy_cnt
);

  logic [NREG-1:0] busy_q, busy_d;
  logic [AW:0]     cnt;

  always_comb begin
    busy_d = busy_q;
    for (int unsigned k = 0; k < NWR; k++) begin
      if (clr_en[k]) busy_d[clr_addr[k*AW +: AW]] = 1'b0;
    end
    if (iss_set) busy_d[iss_addr] = 1'b1;
    if (flush) busy_d = '0;
    if (ZERO_R0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // One bit wider than AW so a fully busy file reports NREG rather than wrapping.
  always_comb begin
    cnt = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      cnt = cnt + {{AW{1'b0}}, busy_q[r]};
    end
  end

  assign busy_vec = busy_q;
  assign busy_cnt = cnt;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with write-to-read bypass and a busy scoreboard.
module regfile_mp_sb
  import regfile_mp_sb_pkg::*;
#(
  parameter int unsigned XLEN    = XLEN_DEF,
  parameter int unsigned NREG    = 2 ** AW_DEF,
  parameter int unsigned AW      = $clog2(NREG),
  parameter int unsigned NRD     = 2,
  parameter int unsigned NWR     = 2,
  parameter bit          ZERO_R0 = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   waddr,
  input  logic [NWR*XLEN-1:0] wdata,
  input  logic [NWR-1:0]      wclr,
  input  logic [NRD-1:0]      re,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic                iss_set,
  input  logic [AW-1:0]       iss_addr,
  input  logic                flush,
  output logic [NREG-1:0]     busy_vec,
  output logic [AW:0]         busy_cnt
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];

  logic [AW-1:0]   waddr_a [NWR];
  logic [XLEN-1:0] wdata_a [NWR];
  logic [NWR-1:0]  wen;
  logic [NWR-1:0]  clr_en;

  for (genvar k = 0; k < NWR; k++) begin : g_wr
    assign waddr_a[k] = waddr[k*AW +: AW];
    assign wdata_a[k] = wdata[k*XLEN +: XLEN];
    assign wen[k]     = (we[k] == WR_EN) && !(ZERO_R0 && (waddr_a[k] == '0));
    assign clr_en[k]  = (we[k] == WR_EN) && wclr[k];
  end

  // Later ports overwrite earlier ones, so the highest index wins on a collision.
  always_comb begin
    regs_d = regs_q;
    for (int unsigned k = 0; k < NWR; k++) begin
      if (wen[k]) regs_d[waddr_a[k]] = wdata_a[k];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      for (int unsigned r = 0; r < NREG; r++) regs_q[r] <= XLEN'(ZEROWORD);
    end else begin
      regs_q <= regs_d;
    end
  end

  for (genvar j = 0; j < NRD; j++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;
    logic            rb;

    assign ra = raddr[j*AW +: AW];

    always_comb begin
      rd = XLEN'(ZEROWORD);
      rb = 1'b0;
      if ((rst != RST_ACTIVE) && (re[j] == RD_EN) && !(ZERO_R0 && (ra == '0))) begin
        rd = regs_q[ra];
        rb = busy_vec[ra];
        for (int unsigned k = 0; k < NWR; k++) begin
          if (wen[k] && (waddr_a[k] == ra)) begin
            rd = wdata_a[k];
            // The retiring producer's value arrives through the bypass.
            if (wclr[k]) rb = 1'b0;
          end
        end
      end
    end

    assign rdata[j*XLEN +: XLEN] = rd;
    assign rbusy[j]              = rb;
  end

  regfile_scoreboard #(
    .NREG    (NREG),
    .AW      (AW),
    .NWR     (NWR),
    .ZERO_R0 (ZERO_R0)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .iss_set  (iss_set),
    .iss_addr (iss_addr),
    .flush    (flush),
    .clr_en   (clr_en),
    .clr_addr (waddr),
    .busy_vec (busy_vec),
    .busy_cnt (busy_cnt)
  );

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb with default parameters (64-bit, 32 regs, 2R/2W, r0 = 0).
module tb_regfile_mp_sb;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   we;
  logic [9:0]   waddr;
  logic [127:0] wdata;
  logic [1:0]   wclr;
  logic [1:0]   re;
  logic [9:0]   raddr;
  logic [127:0] rdata;
  logic [1:0]   rbusy;
  logic         iss_set;
  logic [4:0]   iss_addr;
  logic         flush;
  logic [31:0]  busy_vec;
  logic [5:0]   busy_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_mp_sb dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .wclr     (wclr),
    .re       (re),
    .raddr    (raddr),
    .rdata    (rdata),
    .rbusy    (rbusy),
    .iss_set  (iss_set),
    .iss_addr (iss_addr),
    .flush    (flush),
    .busy_vec (busy_vec),
    .busy_cnt (busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = '0; wclr = '0; iss_set = 1'b0; iss_addr = '0; flush = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    waddr = '0;
    wdata = '0;
    re    = 2'b11;
    raddr = {5'd7, 5'd5};
    #1;
    chk("reset_rdata", rdata, 128'h0);
    chk("reset_busy_vec", busy_vec, 32'h0);
    chk("reset_busy_cnt", busy_cnt, 6'd0);
    chk("reset_rbusy", rbusy, 2'b00);
    repeat (3) step();
    rst = 1'b1;
    #1;
    chk("post_reset_read", rdata, 128'h0);

    // Write collision: port 1 wins, and the bypass shows it the same cycle.
    we    = 2'b11;
    waddr = {5'd3, 5'd3};
    wdata = {64'h22, 64'h11};
    raddr = {5'd4, 5'd3};
    #1;
    chk("bypass_hi_port", rdata[63:0], 64'h22);
    chk("bypass_other_port", rdata[127:64], 64'h0);
    step();
    idle();
    raddr = {5'd3, 5'd3};
    #1;
    chk("reg3_stored", rdata, {64'h22, 64'h22});
    re = 2'b00;
    #1;
    chk("re_low_zero", rdata, 128'h0);
    re = 2'b11;

    // r0 stays zero and never busy.
    we = 2'b01; waddr = {5'd0, 5'd0}; wdata = {64'h0, 64'hDEAD};
    iss_set = 1'b1; iss_addr = 5'd0;
    raddr = {5'd0, 5'd0};
    #1;
    chk("r0_bypass_suppressed", rdata[63:0], 64'h0);
    step();
    idle();
    #1;
    chk("r0_read_zero", rdata[63:0], 64'h0);
    chk("r0_not_busy", busy_vec, 32'h0);
    chk("r0_cnt", busy_cnt, 6'd0);

    // Scoreboard lifecycle on r5.
    iss_set = 1'b1; iss_addr = 5'd5;
    raddr = {5'd5, 5'd5};
    #1;
    chk("iss_same_cycle_rbusy", rbusy, 2'b00);
    step();
    idle();
    #1;
    chk("r5_busy_vec", busy_vec, 32'h0000_0020);
    chk("r5_busy_cnt", busy_cnt, 6'd1);
    chk("r5_rbusy", rbusy, 2'b11);
    we = 2'b01; wclr = 2'b01; waddr = {5'd0, 5'd5}; wdata = {64'h0, 64'h55};
    #1;
    chk("wclr_rbusy_forced", rbusy, 2'b00);
    chk("wclr_bypass_data", rdata, {64'h55, 64'h55});
    step();
    idle();
    #1;
    chk("r5_cleared", busy_vec, 32'h0);
    chk("r5_data", rdata[63:0], 64'h55);

    // Write without wclr keeps the register busy.
    iss_set = 1'b1; iss_addr = 5'd6;
    step();
    idle();
    we = 2'b10; waddr = {5'd6, 5'd0}; wdata = {64'h66, 64'h0};
    raddr = {5'd6, 5'd6};
    #1;
    chk("nowclr_rbusy", rbusy, 2'b11);
    chk("nowclr_bypass", rdata, {64'h66, 64'h66});
    step();
    idle();
    #1;
    chk("nowclr_still_busy", busy_vec, 32'h0000_0040);

    // Set beats a simultaneous clear on r9 (clear via port 1).
    iss_set = 1'b1; iss_addr = 5'd9;
    we = 2'b10; wclr = 2'b10; waddr = {5'd9, 5'd0}; wdata = {64'h99, 64'h0};
    step();
    idle();
    #1;
    chk("set_beats_clear", busy_vec, 32'h0000_0240);
    chk("set_beats_clear_cnt", busy_cnt, 6'd2);

    // Flush beats a simultaneous set.
    iss_set = 1'b1; iss_addr = 5'd4; flush = 1'b1;
    step();
    idle();
    #1;
    chk("flush_vec", busy_vec, 32'h0);
    chk("flush_cnt", busy_cnt, 6'd0);
    raddr = {5'd9, 5'd6};
    #1;
    chk("flush_keeps_data", rdata, {64'h99, 64'h66});

    // Mark every register busy: count reaches 31 (r0 excluded), no wrap.
    for (int r = 0; r < 32; r++) begin
      iss_set = 1'b1; iss_addr = r[4:0];
      step();
    end
    idle();
    #1;
    chk("all_busy_vec", busy_vec, 32'hFFFF_FFFE);
    chk("all_busy_cnt", busy_cnt, 6'd31);

    // Asynchronous reset between edges while a write is pending.
    we = 2'b01; waddr = {5'd0, 5'd12}; wdata = {64'h0, 64'hFF};
    raddr = {5'd12, 5'd12};
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_busy_vec", busy_vec, 32'h0);
    chk("async_rst_busy_cnt", busy_cnt, 6'd0);
    chk("async_rst_rdata", rdata, 128'h0);
    step();
    idle();
    rst = 1'b1;
    #1;
    chk("r12_after_reset", rdata, 128'h0);
    raddr = {5'd6, 5'd3};
    #1;
    chk("regs_cleared", rdata, 128'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
